// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single-port, byte-addressed main memory between
// instruction fetch (IF) and data load/store (D) requesters.
// Each grant owns the memory for one ACCESS cycle; completion is reported with
// a one-cycle rvalid pulse on the following cycle. D has fixed priority over IF,
// but IF is forced to win once D has taken STARVE_LIMIT consecutive grants
// while IF was waiting.
// Optional feature: define MEMARB_RANGE_CHECK_EN to flag accesses that fall
// outside [STARTING_ADDR, STARTING_ADDR + MEM_DEPTH_BYTES - 4] with err and
// 32'hDEADBEEF read data, suppressing the actual memory access.
module mem_port_arbiter #(
    parameter logic [31:0] STARTING_ADDR   = 32'h0100_0000,
    parameter logic [31:0] MEM_DEPTH_BYTES = 32'h0010_0000,
    parameter int unsigned STARVE_LIMIT    = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_read_write,
    input  logic [31:0] mem_data_out
);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] ERR_DATA  = 32'hDEAD_BEEF;

    // True when a word-aligned address lies outside the populated memory window.
    function automatic logic addr_out_of_range(input logic [31:0] a);
        return (a < STARTING_ADDR) || (a > (STARTING_ADDR + MEM_DEPTH_BYTES - 32'd4));
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   starve_q, starve_d;
    logic            owner_q, owner_d;      // 1 = D, 0 = IF
    logic            we_q, we_d;
    logic            err_q, err_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     if_rdata_q, if_rdata_d;
    logic [31:0]     d_rdata_q, d_rdata_d;
    logic            if_rvalid_q, if_rvalid_d;
    logic            d_rvalid_q, d_rvalid_d;
    logic            if_err_q, if_err_d;
    logic            d_err_q, d_err_d;

    logic            if_gnt_s, d_gnt_s;
    logic [31:0]     sel_addr_s;
    logic            range_err_s;
    logic [31:0]     rdata_s;

    // Grant decision: only in IDLE, D first unless IF has been starved long enough.
    always_comb begin
        if_gnt_s = 1'b0;
        d_gnt_s  = 1'b0;
        if (state_q == IDLE) begin
            d_gnt_s  = d_req && !(if_req && (starve_q == STARVE_MAX));
            if_gnt_s = if_req && !d_gnt_s;
        end else begin
            if_gnt_s = 1'b0;
            d_gnt_s  = 1'b0;
        end
    end

    assign sel_addr_s = d_gnt_s ? (d_addr & WORD_MASK) : (if_addr & WORD_MASK);

`ifdef MEMARB_RANGE_CHECK_EN
    assign range_err_s = addr_out_of_range(sel_addr_s);
`else
    assign range_err_s = 1'b0;
`endif

    // Next-state logic: every grant is followed by exactly one ACCESS cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (if_gnt_s || d_gnt_s) begin
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch, completion write-back and starvation bookkeeping.
    always_comb begin
        owner_d     = owner_q;
        we_d        = we_q;
        err_d       = err_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_err_d    = 1'b0;
        d_err_d     = 1'b0;
        starve_d    = starve_q;
        rdata_s     = 32'd0;

        if (d_gnt_s) begin
            owner_d = 1'b1;
            we_d    = d_we;
            addr_d  = sel_addr_s;
            wdata_d = d_wdata;
            err_d   = range_err_s;
        end else if (if_gnt_s) begin
            owner_d = 1'b0;
            we_d    = 1'b0;
            addr_d  = sel_addr_s;
            wdata_d = 32'd0;
            err_d   = range_err_s;
        end else begin
            owner_d = owner_q;
        end

        if (state_q == ACCESS) begin
            if (err_q) begin
                rdata_s = ERR_DATA;
            end else if (we_q) begin
                rdata_s = 32'd0;
            end else begin
                rdata_s = mem_data_out;
            end
            if (owner_q) begin
                d_rdata_d  = rdata_s;
                d_rvalid_d = 1'b1;
                d_err_d    = err_q;
            end else begin
                if_rdata_d  = rdata_s;
                if_rvalid_d = 1'b1;
                if_err_d    = err_q;
            end
        end else begin
            rdata_s = 32'd0;
        end

        if (!if_req || if_gnt_s) begin
            starve_d = {CW{1'b0}};
        end else if (d_gnt_s && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + CW'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    // Memory port: driven from the latched request only during a valid ACCESS cycle.
    always_comb begin
        if ((state_q == ACCESS) && !err_q) begin
            mem_address    = addr_q;
            mem_data_in    = wdata_q;
            mem_read_write = we_q;
        end else begin
            mem_address    = STARTING_ADDR;
            mem_data_in    = 32'd0;
            mem_read_write = 1'b0;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            starve_q    <= {CW{1'b0}};
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= STARTING_ADDR;
            wdata_q     <= 32'd0;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= 32'd0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_err_q    <= 1'b0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_err_q    <= if_err_d;
            d_err_q     <= d_err_d;
        end
    end

    assign if_gnt    = if_gnt_s;
    assign d_gnt     = d_gnt_s;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign if_err    = if_err_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// single transactions, checked against a word-level shadow memory and the
// arbitration rules (priority, starvation limit, latency, range check).
module tb_mem_port_arbiter;

    localparam logic [31:0] BASE  = 32'h0100_0000;
    localparam logic [31:0] DEPTH = 32'h0010_0000;
    localparam int          LIMIT = 2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic [31:0] mem_address, mem_data_in, mem_data_out;
    logic        mem_read_write;

    logic [31:0] mem     [0:255];   // the memory device itself
    logic [31:0] ref_mem [0:255];   // what the bench believes the memory holds

    int pass_cnt  = 0;
    int total_cnt = 0;

    mem_port_arbiter #(
        .STARTING_ADDR   (BASE),
        .MEM_DEPTH_BYTES (DEPTH),
        .STARVE_LIMIT    (LIMIT)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_gnt         (if_gnt),
        .if_rvalid      (if_rvalid),
        .if_rdata       (if_rdata),
        .if_err         (if_err),
        .d_req          (d_req),
        .d_we           (d_we),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_gnt          (d_gnt),
        .d_rvalid       (d_rvalid),
        .d_rdata        (d_rdata),
        .d_err          (d_err),
        .mem_address    (mem_address),
        .mem_data_in    (mem_data_in),
        .mem_read_write (mem_read_write),
        .mem_data_out   (mem_data_out)
    );

    always #5 clock = ~clock;

    // Memory device: combinational read, store committed at the rising edge.
    assign mem_data_out = mem[mem_address[9:2]];
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'h5A00_0000 ^ (i * 32'h0001_0203);
            ref_mem[i] = 32'h5A00_0000 ^ (i * 32'h0001_0203);
        end
        mem[2]     = 32'h00A0_0093;
        ref_mem[2] = 32'h00A0_0093;
        forever begin
            @(posedge clock);
            if (mem_read_write) mem[mem_address[9:2]] = mem_data_in;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic bit out_of_range(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
`ifdef MEMARB_RANGE_CHECK_EN
        return (w < BASE) || (w > BASE + DEPTH - 32'd4);
`else
        return 1'b0;
`endif
    endfunction

    // One complete transaction; entered away from a clock edge with the DUT idle
    // or about to become idle, returns at the cycle carrying rvalid.
    task automatic access(input bit is_d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata);
        bit          err;
        bit          got;
        logic [31:0] exp_rdata;
        logic [31:0] exp_addr;
        int          idx;
        err = out_of_range(addr);
        idx = int'(addr[9:2]);
        exp_addr  = err ? BASE : (addr & 32'hFFFF_FFFC);
        exp_rdata = err ? 32'hDEAD_BEEF : (we ? 32'd0 : ref_mem[idx]);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        #1;
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if ((is_d && d_gnt) || (!is_d && if_gnt)) begin
                got = 1'b1;
                break;
            end
            @(posedge clock); #1;
        end
        check("grant_seen", {31'd0, got}, 32'd1);
        if (!got) begin
            d_req = 1'b0; if_req = 1'b0;
            return;
        end
        check("other_gnt_low", {31'd0, is_d ? if_gnt : d_gnt}, 32'd0);
        @(posedge clock); #1;
        d_req = 1'b0; if_req = 1'b0;
        check("acc_mem_addr", mem_address, exp_addr);
        check("acc_mem_rw", {31'd0, mem_read_write}, {31'd0, we && !err});
        if (we && !err) check("acc_mem_din", mem_data_in, wdata);
        check("acc_gnts_low", {30'd0, if_gnt, d_gnt}, 32'd0);
        check("acc_rvalid_low", {30'd0, if_rvalid, d_rvalid}, 32'd0);
        @(posedge clock); #1;
        if (we && !err) ref_mem[idx] = wdata;
        check("done_mem_rw", {31'd0, mem_read_write}, 32'd0);
        if (is_d) begin
            check("d_rvalid", {31'd0, d_rvalid}, 32'd1);
            check("if_rvalid_quiet", {31'd0, if_rvalid}, 32'd0);
            check("d_rdata", d_rdata, exp_rdata);
            check("d_err", {31'd0, d_err}, {31'd0, err});
        end else begin
            check("if_rvalid", {31'd0, if_rvalid}, 32'd1);
            check("d_rvalid_quiet", {31'd0, d_rvalid}, 32'd0);
            check("if_rdata", if_rdata, exp_rdata);
            check("if_err", {31'd0, if_err}, {31'd0, err});
        end
    endtask

    initial begin
        int          d_in_row;
        bit          exp_if;
        bit          prev_if;
        bit          is_d, we;
        logic [31:0] addr;

        // Reset state while reset is held.
        #1;
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
        check("rst_err", {30'd0, if_err, d_err}, 32'd0);
        check("rst_mem_addr", mem_address, BASE);
        check("rst_mem_rw", {31'd0, mem_read_write}, 32'd0);
        check("rst_mem_din", mem_data_in, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;

        // Idle for 5 cycles: no grant, memory port parked.
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            check("idle_gnt", {30'd0, if_gnt, d_gnt}, 32'd0);
            check("idle_mem_rw", {31'd0, mem_read_write}, 32'd0);
            check("idle_mem_addr", mem_address, BASE);
        end

        // Fetch of a known instruction word.
        access(1'b0, 1'b0, 32'h0100_0008, 32'd0);
        check("fetch_word", if_rdata, 32'h00A0_0093);

        // Store then load of the same word.
        access(1'b1, 1'b1, 32'h0100_0010, 32'hCAFE_F00D);
        access(1'b1, 1'b0, 32'h0100_0010, 32'd0);
        check("store_load", d_rdata, 32'hCAFE_F00D);
        check("fetch_rdata_hold", if_rdata, 32'h00A0_0093);

        // Both requesters held: D wins until it has taken LIMIT grants in a row
        // while IF waited, then IF is served.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0100_0040;
        if_req = 1'b1; if_addr = 32'h0100_0044;
        d_in_row = 0;
        prev_if  = 1'b0;
        #1;
        for (int k = 0; k < 12; k++) begin
            if (k % 2 == 0) begin
                exp_if = (d_in_row == LIMIT);
                d_in_row = exp_if ? 0 : d_in_row + 1;
                check("starve_if_gnt", {31'd0, if_gnt}, {31'd0, exp_if});
                check("starve_d_gnt", {31'd0, d_gnt}, {31'd0, !exp_if});
                if (k > 0) begin
                    check("starve_if_rvalid", {31'd0, if_rvalid}, {31'd0, prev_if});
                    check("starve_d_rvalid", {31'd0, d_rvalid}, {31'd0, !prev_if});
                end
                prev_if = exp_if;
            end else begin
                check("starve_access_gnt", {30'd0, if_gnt, d_gnt}, 32'd0);
            end
            @(posedge clock); #1;
        end
        d_req = 1'b0; if_req = 1'b0;
        check("starve_last_if_rvalid", {31'd0, if_rvalid}, {31'd0, prev_if});
        check("starve_last_rdata", prev_if ? if_rdata : d_rdata, prev_if ? ref_mem[17] : ref_mem[16]);
        @(posedge clock); #1;

        // Reset during the ACCESS cycle of a store: nothing commits.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0100_0020; d_wdata = ~ref_mem[8];
        #1;
        check("rst_mid_gnt", {31'd0, d_gnt}, 32'd1);
        @(posedge clock); #1;
        d_req = 1'b0; d_we = 1'b0;
        check("rst_mid_rw_before", {31'd0, mem_read_write}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_rw_after", {31'd0, mem_read_write}, 32'd0);
        check("rst_mid_addr", mem_address, BASE);
        @(posedge clock); #1;
        check("rst_mid_no_rvalid", {31'd0, d_rvalid}, 32'd0);
        check("rst_mid_rdata", d_rdata, 32'd0);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;
        check("rst_mid_no_rvalid2", {31'd0, d_rvalid}, 32'd0);
        access(1'b1, 1'b0, 32'h0100_0020, 32'd0);
        check("rst_mid_old_word", d_rdata, mem[8]);

`ifdef MEMARB_RANGE_CHECK_EN
        // Range boundaries: below base, last word, one past the end.
        access(1'b1, 1'b0, 32'h0000_0100, 32'd0);
        check("oor_low_rdata", d_rdata, 32'hDEAD_BEEF);
        access(1'b1, 1'b1, BASE - 32'd4, 32'h1111_2222);
        access(1'b0, 1'b0, BASE + DEPTH - 32'd4, 32'd0);
        access(1'b1, 1'b0, BASE + DEPTH, 32'd0);
`endif

        // Randomized mix of fetches, loads and stores, sometimes with misaligned
        // byte addresses and, when range checking is built in, wild addresses.
        for (int n = 0; n < 60; n++) begin
            is_d = 1'($urandom_range(0, 1));
            we   = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
            addr = BASE + (32'($urandom_range(0, 63)) << 2) + 32'($urandom_range(0, 3));
`ifdef MEMARB_RANGE_CHECK_EN
            if ($urandom_range(0, 7) == 0) addr = $urandom;
`endif
            access(is_d, we, addr, $urandom);
        end

        @(posedge clock); #1;
        check("final_idle_rw", {31'd0, mem_read_write}, 32'd0);
        check("final_idle_addr", mem_address, BASE);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single-port, byte-addressed main memory and shares it between two requesters: instruction fetch (IF) and data load/store (D).
- Sits between the core and main memory. Drives the memory's address, data_in and read_write, and samples its combinational data_out.
- One word access per grant, two-cycle occupancy.
- Fixed data-over-fetch priority, with a starvation limit that guarantees forward progress for fetch.

Parameters:
- STARTING_ADDR, 'h01000000, base byte address of main memory.
- MEM_DEPTH_BYTES, 'h0100000, memory size in bytes; used only by the optional range check.
- STARVE_LIMIT, 2, consecutive D grants allowed while if_req is pending before IF is forced to win.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  combinational accept pulse; the request is taken at this edge.
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  32  registered fetch data.
- if_err  out  1  range error, qualified by if_rvalid.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_gnt  out  1  combinational accept pulse.
- d_rvalid  out  1  one-cycle completion pulse; pulses for both loads and stores.
- d_rdata  out  32  registered load data; 0 on stores.
- d_err  out  1  range error, qualified by d_rvalid.
- mem_address  out  32  to memory address.
- mem_data_in  out  32  to memory data_in.
- mem_read_write  out  1  to memory read_write; 0 = READ, 1 = WRITE.
- mem_data_out  in  32  from memory data_out (combinational read).

Behaviour:
- Reset (asynchronous, takes effect immediately), applied as follows:
  - State: IDLE; starvation counter = 0.
  - Data outputs: if_rdata = d_rdata = 0.
  - Strobes: rvalid and err outputs = 0; gnts = 0.
  - Memory port: mem_read_write = READ, mem_address = STARTING_ADDR, mem_data_in = 0.
- FSM with states IDLE and ACCESS.
- IDLE:
  - Grant decision is combinational; at most one gnt high per cycle.
  - Priority: d_req wins unless if_req=1 and starve count == STARVE_LIMIT, in which case IF wins.
  - On the posedge with a gnt high:
    - Latch owner, we (forced 0 for IF), word-aligned address (addr[1:0] cleared) and wdata.
    - Go to ACCESS.
  - No request: remain in IDLE with the memory port at reset values.
- ACCESS (exactly one cycle):
  - Memory port is driven from the latched registers; mem_read_write = latched we.
  - gnts are held low.
  - At the closing posedge:
    - Memory commits a store.
    - Owner's rdata <= mem_data_out for a load, or 0 for a store.
    - Owner's rvalid pulses high for the following cycle.
    - Return to IDLE.
- Latency and throughput:
  - gnt at edge N; memory access in cycle N..N+1; rvalid high in cycle N+1..N+2.
  - Peak throughput: one access per 2 cycles.
  - A new gnt may coincide with the previous rvalid.
- Starvation counter:
  - +1 on each D grant while if_req=1, saturating at STARVE_LIMIT.
  - Cleared on any IF grant, or when if_req=0.
- mem_read_write is high only during an ACCESS cycle of a store; it is never high in IDLE.
- Reset mid-ACCESS: mem_read_write drops to READ asynchronously, so the store does not commit. No rvalid is produced; the requester reissues.
- rdata holds its value between rvalid pulses.
- Requests that drop before gnt are ignored; there is no abort after gnt.

Optional Feature:
- Macro MEMARB_RANGE_CHECK_EN.
- Defined: at latch time, the address is in range when STARTING_ADDR <= addr <= STARTING_ADDR + MEM_DEPTH_BYTES - 4 (32-bit unsigned compare). For an out-of-range address:
  - The ACCESS cycle keeps mem_read_write = READ and mem_address = STARTING_ADDR.
  - The returned rdata is 32'hDEADBEEF.
  - The owner's err pulses together with its rvalid.
- Undefined: no check is performed; if_err and d_err are tied to 0.

Test Plan:
- Reset, then d_req=0 and if_req=0 for 5 cycles -> no gnt, mem_read_write=0, mem_address='h01000000 throughout.
- if_req, if_addr='h01000008, memory word there = 'h00A00093 -> if_gnt at edge N, if_rvalid at N+1 with if_rdata='h00A00093.
- Store d_we=1, d_addr='h01000010, d_wdata='hCAFEF00D, then load the same address -> d_rvalid for both; the load returns 'hCAFEF00D; mem_read_write high for exactly one cycle.
- if_req and d_req held continuously, STARVE_LIMIT=2 -> grant order D, D, IF, D, D, IF; no requester waits more than 6 cycles.
- Assert reset_n=0 during the ACCESS cycle of a store to 'h01000020 -> no d_rvalid; a later load of 'h01000020 returns the old contents.
- With MEMARB_RANGE_CHECK_EN: load from 'h00000100 -> d_rvalid with d_err=1, d_rdata='hDEADBEEF, mem_address stays 'h01000000. Without the macro -> d_err always 0.
